// File: rtl/cceip_job_ctrl.sv
// cceip_job_ctrl - job sequencer in front of the CCEIP datapath AXI masters.
//
// Accepts one ap_ctrl_hs job, splits the input buffer into read bursts that
// never cross a 4KB page, arms the output write engine, waits for the core's
// end-of-output, writes the 64-bit output byte count to output_size_addr and
// completes the host handshake.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   ap_start/idle/done/ready  ap_ctrl_hs host handshake
//   input_size/input_addr     input buffer length (bytes) and base
//   output_addr               output buffer base, forwarded on wr_base
//   output_size_addr          destination of the output byte count
//   rd_cmd_*                  read command channel (valid/ready), rd_cmpl return pulse
//   wr_start/wr_base          write engine arm pulse and base address
//   out_done/out_bytes        end-of-output pulse and total byte count
//   sz_*                      size-word write request (valid/ready)
//   dbg_state                 current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, valid and its payload stay stable until accepted.
//
// Optional feature: define CCEIP_JOB_CTRL_TIMEOUT_EN to add a 32-bit watchdog
// on RD_DRAIN/WAIT_OUT that forces an all-ones size word on expiry.
module cceip_job_ctrl #(
    parameter int ADDR_W          = 64,
    parameter int DATA_BYTES      = 64,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              ap_ready,
    input  logic [63:0]       input_size,
    input  logic [63:0]       input_addr,
    input  logic [63:0]       output_addr,
    input  logic [63:0]       output_size_addr,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [7:0]        rd_cmd_len,
    output logic              rd_cmd_last,
    input  logic              rd_cmpl,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_base,
    input  logic              out_done,
    input  logic [63:0]       out_bytes,
    output logic              sz_valid,
    input  logic              sz_ready,
    output logic [ADDR_W-1:0] sz_addr,
    output logic [63:0]       sz_data,
    output logic [2:0]        dbg_state
);

    localparam int LOG2  = $clog2(DATA_BYTES);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [63:0] BEAT_MASK = 64'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_DRAIN = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_SZ_WR    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       rem_q, rem_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] sz_addr_q, sz_addr_d;
    logic [63:0]       sz_data_q, sz_data_d;
    logic              done_seen_q, done_seen_d;
    logic              wr_start_q, wr_start_d;
`ifdef CCEIP_JOB_CTRL_TIMEOUT_EN
    logic [31:0]       wdog_q, wdog_d;
`endif

    // Burst sizing: remaining beats, beats left in the current 4KB page.
    logic [63:0] beats_left, page_beats, burst64, burst_bytes;
    logic [12:0] page_left;
    logic        cmd_last, issue, accept, cmpl_dec;

    always_comb begin
        beats_left  = (rem_q >> LOG2) + {63'd0, |(rem_q & BEAT_MASK)};
        page_left   = 13'h1000 - {1'b0, addr_q[11:0]};
        page_beats  = 64'(page_left >> LOG2);
        burst64     = beats_left;
        if (burst64 > 64'(MAX_BURST)) burst64 = 64'(MAX_BURST);
        if (burst64 > page_beats)     burst64 = page_beats;
        burst_bytes = burst64 << LOG2;
        cmd_last    = (burst64 == beats_left);
    end

    assign issue        = (state_q == S_RD_ISSUE);
    assign rd_cmd_valid = issue && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign rd_cmd_addr  = issue ? addr_q : '0;
    assign rd_cmd_len   = issue ? 8'(burst64 - 64'd1) : 8'd0;
    assign rd_cmd_last  = issue && cmd_last;
    assign accept       = rd_cmd_valid && rd_cmd_ready;
    // A completion with nothing outstanding is stray and must not underflow.
    assign cmpl_dec     = rd_cmpl && (outst_q != '0);

    assign ap_idle   = (state_q == S_IDLE);
    assign ap_done   = (state_q == S_DONE);
    assign ap_ready  = (state_q == S_DONE);
    assign sz_valid  = (state_q == S_SZ_WR);
    assign sz_addr   = sz_addr_q;
    assign sz_data   = sz_data_q;
    assign wr_start  = wr_start_q;
    assign wr_base   = wr_base_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        wr_base_d   = wr_base_q;
        sz_addr_d   = sz_addr_q;
        sz_data_d   = sz_data_q;
        done_seen_d = done_seen_q;
        wr_start_d  = 1'b0;
        outst_d     = outst_q;
        if (accept && !cmpl_dec)      outst_d = outst_q + 1'b1;
        else if (!accept && cmpl_dec) outst_d = outst_q - 1'b1;

        // End-of-output can race ahead of the read phase; remember it.
        if (out_done && (state_q == S_RD_ISSUE || state_q == S_RD_DRAIN)) begin
            done_seen_d = 1'b1;
            sz_data_d   = out_bytes;
        end

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    addr_d      = input_addr[ADDR_W-1:0] & ~BEAT_MASK[ADDR_W-1:0];
                    rem_d       = input_size;
                    wr_base_d   = output_addr[ADDR_W-1:0];
                    sz_addr_d   = output_size_addr[ADDR_W-1:0];
                    sz_data_d   = '0;
                    done_seen_d = 1'b0;
                    wr_start_d  = 1'b1;
                    outst_d     = '0;
                    state_d     = (input_size == 64'd0) ? S_WAIT_OUT : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + burst_bytes[ADDR_W-1:0];
                    rem_d  = (rem_q <= burst_bytes) ? 64'd0 : rem_q - burst_bytes;
                    if (cmd_last) state_d = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                if (outst_q == '0) state_d = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                if (out_done) begin
                    sz_data_d = out_bytes;
                    state_d   = S_SZ_WR;
                end else if (done_seen_q) begin
                    state_d = S_SZ_WR;
                end
            end
            S_SZ_WR: begin
                if (sz_ready) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef CCEIP_JOB_CTRL_TIMEOUT_EN
        wdog_d = '0;
        if ((state_q == S_RD_DRAIN || state_q == S_WAIT_OUT) && !(rd_cmpl || out_done)) begin
            wdog_d = wdog_q + 32'd1;
            if (wdog_q == 32'hFFFF_FFFF) begin
                state_d   = S_SZ_WR;
                sz_data_d = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            outst_q     <= '0;
            wr_base_q   <= '0;
            sz_addr_q   <= '0;
            sz_data_q   <= '0;
            done_seen_q <= 1'b0;
            wr_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            outst_q     <= outst_d;
            wr_base_q   <= wr_base_d;
            sz_addr_q   <= sz_addr_d;
            sz_data_q   <= sz_data_d;
            done_seen_q <= done_seen_d;
            wr_start_q  <= wr_start_d;
        end
    end

`ifdef CCEIP_JOB_CTRL_TIMEOUT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) wdog_q <= '0;
        else           wdog_q <= wdog_d;
    end
`endif

endmodule

// File: tb/tb_cceip_job_ctrl.sv
// Testbench for cceip_job_ctrl: table of jobs with expected read commands,
// plus directed sequences for outstanding limit, early out_done and reset.
module tb_cceip_job_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_ISSUE = 3'd1, ST_WAIT = 3'd3, ST_SZ = 3'd4;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_idle, ap_done, ap_ready;
    logic [63:0] input_size = '0, input_addr = '0, output_addr = '0, output_size_addr = '0;
    logic        rd_cmd_valid, rd_cmd_last, wr_start, sz_valid;
    logic        rd_cmd_ready = 1'b0, rd_cmpl = 1'b0, out_done = 1'b0, sz_ready = 1'b0;
    logic [63:0] rd_cmd_addr, wr_base, sz_addr, sz_data;
    logic [63:0] out_bytes = '0;
    logic [7:0]  rd_cmd_len;
    logic [2:0]  dbg_state;

    cceip_job_ctrl dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
        .input_size(input_size), .input_addr(input_addr),
        .output_addr(output_addr), .output_size_addr(output_size_addr),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_cmd_last(rd_cmd_last),
        .rd_cmpl(rd_cmpl), .wr_start(wr_start), .wr_base(wr_base),
        .out_done(out_done), .out_bytes(out_bytes),
        .sz_valid(sz_valid), .sz_ready(sz_ready), .sz_addr(sz_addr), .sz_data(sz_data),
        .dbg_state(dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int cmpl_cnt = 0;
    int ws_cnt = 0;
    bit cmpl_en = 1'b1;
    logic [72:0] exp_q[$];

    typedef struct {
        logic [63:0]      in_addr;
        logic [63:0]      in_size;
        logic [63:0]      obytes;
        int               ncmd;
        logic [3:0][63:0] c_addr;
        logic [3:0][7:0]  c_len;
    } job_t;
    job_t jobs[6];

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted read command must match the head of exp_q.
    always @(negedge ap_clk) begin
        if (wr_start) ws_cnt++;
        if (rd_cmd_valid && rd_cmd_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_cmd_unexpected: got addr=%h len=%0d last=%0b expected none",
                         rd_cmd_addr, rd_cmd_len, rd_cmd_last);
            end else begin
                chk("rd_cmd", {rd_cmd_addr, rd_cmd_len, rd_cmd_last}, exp_q.pop_front());
            end
        end
    end

    // Read engine model: one completion per cycle for each accepted command.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (cmpl_en && acc_cnt > cmpl_cnt) begin
                rd_cmpl = 1'b1;
                cmpl_cnt++;
            end else begin
                rd_cmpl = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_job(input int i, input logic [63:0] a, input logic [63:0] s,
                           input logic [63:0] ob, input int n,
                           input logic [63:0] a0, input logic [7:0] l0,
                           input logic [63:0] a1, input logic [7:0] l1,
                           input logic [63:0] a2, input logic [7:0] l2);
        jobs[i].in_addr = a;  jobs[i].in_size = s; jobs[i].obytes = ob; jobs[i].ncmd = n;
        jobs[i].c_addr[0] = a0; jobs[i].c_len[0] = l0;
        jobs[i].c_addr[1] = a1; jobs[i].c_len[1] = l1;
        jobs[i].c_addr[2] = a2; jobs[i].c_len[2] = l2;
        jobs[i].c_addr[3] = '0; jobs[i].c_len[3] = '0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (dbg_state == s) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, state=%0d expected %0d", name, dbg_state, s);
    endtask

    task automatic start_job(input logic [63:0] a, input logic [63:0] s);
        input_addr       = a;
        input_size       = s;
        output_addr      = 64'hA000_0000 + a;
        output_size_addr = 64'hB000_0000 + s;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        chk("start_idle", 73'(ap_idle), 73'd0);
        chk("start_wr_start", 73'(wr_start), 73'd1);
        chk("start_wr_base", 73'(wr_base), 73'(output_addr));
        tick();
        chk("wr_start_pulse", 73'(wr_start), 73'd0);
    endtask

    task automatic pulse_out_done(input logic [63:0] b);
        out_bytes = b;
        out_done  = 1'b1;
        tick();
        out_done  = 1'b0;
        out_bytes = $urandom();
    endtask

    task automatic complete_sz(input logic [63:0] exp_bytes);
        wait_state(ST_SZ, 3000, "wait_sz_wr");
        chk("sz_valid", 73'(sz_valid), 73'd1);
        chk("sz_addr", 73'(sz_addr), 73'(output_size_addr));
        chk("sz_data", 73'(sz_data), 73'(exp_bytes));
        tick();
        chk("sz_valid_hold", {71'd0, sz_valid, ap_done}, {71'd0, 1'b1, 1'b0});
        sz_ready = 1'b1;
        tick();
        sz_ready = 1'b0;
        chk("done_pulse", {70'd0, ap_done, ap_ready, ap_idle}, {70'd0, 3'b110});
        tick();
        chk("done_end", {70'd0, ap_done, ap_ready, ap_idle}, {70'd0, 3'b001});
    endtask

    task automatic run_row(input int i);
        int acc0, ws0;
        acc0 = acc_cnt;
        ws0  = ws_cnt;
        rd_cmd_ready = 1'b1;
        cmpl_en      = 1'b1;
        for (int k = 0; k < jobs[i].ncmd; k++)
            exp_q.push_back({jobs[i].c_addr[k], jobs[i].c_len[k], (k == jobs[i].ncmd - 1)});
        start_job(jobs[i].in_addr, jobs[i].in_size);
        wait_state(ST_WAIT, 3000, "wait_out");
        pulse_out_done(jobs[i].obytes);
        complete_sz(jobs[i].obytes);
        chk("cmd_count", 73'(acc_cnt - acc0), 73'(jobs[i].ncmd));
        chk("wr_start_count", 73'(ws_cnt - ws0), 73'd1);
        chk("exp_q_empty", 73'(exp_q.size()), 73'd0);
    endtask

    initial begin
        logic [72:0] held;
        set_job(0, 64'h1000, 64'd10000, 64'd1234, 3, 64'h1000, 8'd63, 64'h2000, 8'd63, 64'h3000, 8'd28);
        set_job(1, 64'h1F80, 64'd512,   64'd555,  2, 64'h1F80, 8'd1,  64'h2000, 8'd5,  64'h0,    8'd0);
        set_job(2, 64'h2000, 64'd64,    64'd9,    1, 64'h2000, 8'd0,  64'h0,    8'd0,  64'h0,    8'd0);
        set_job(3, 64'h3010, 64'd100,   64'd42,   1, 64'h3000, 8'd1,  64'h0,    8'd0,  64'h0,    8'd0);
        set_job(4, 64'h4FC0, 64'd8192,  64'd8192, 3, 64'h4FC0, 8'd0,  64'h5000, 8'd63, 64'h6000, 8'd62);
        set_job(5, 64'h7000, 64'd0,     64'd0,    0, 64'h0,    8'd0,  64'h0,    8'd0,  64'h0,    8'd0);

        // Reset state
        #12;
        chk("rst_idle", 73'(ap_idle), 73'd1);
        chk("rst_outs", {66'd0, ap_done, ap_ready, rd_cmd_valid, rd_cmd_last, wr_start, sz_valid, rd_cmd_len == 8'd0},
            {66'd0, 7'b0000001});
        chk("rst_data", {9'd0, sz_data}, 73'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        chk("post_rst_state", 73'(dbg_state), 73'(ST_IDLE));

        for (int i = 0; i < 6; i++) run_row(i);

        // Outstanding limit: 20-burst job with completions withheld.
        cmpl_en = 1'b0;
        rd_cmd_ready = 1'b1;
        for (int k = 0; k < 20; k++)
            exp_q.push_back({64'h10000 + 64'(k) * 64'h1000, 8'd63, (k == 19)});
        start_job(64'h10000, 64'd81920);
        repeat (40) tick();
        chk("outst_accepted", 73'(acc_cnt - cmpl_cnt), 73'd8);
        chk("outst_stall", {70'd0, rd_cmd_valid, dbg_state == ST_ISSUE, 1'b0}, {70'd0, 3'b010});
        cmpl_en = 1'b1;
        wait_state(ST_WAIT, 3000, "outst_wait_out");
        pulse_out_done(64'd81920);
        complete_sz(64'd81920);
        chk("outst_exp_empty", 73'(exp_q.size()), 73'd0);

        // out_done arrives while still issuing; payload held while stalled.
        rd_cmd_ready = 1'b0;
        exp_q.push_back({64'h8000, 8'd1, 1'b1});
        start_job(64'h8000, 64'd128);
        held = {rd_cmd_addr, rd_cmd_len, rd_cmd_last};
        pulse_out_done(64'd777);
        tick();
        chk("early_done_state", 73'(dbg_state), 73'(ST_ISSUE));
        chk("hold_payload", {rd_cmd_addr, rd_cmd_len, rd_cmd_last}, held);
        chk("hold_valid", 73'(rd_cmd_valid), 73'd1);
        rd_cmd_ready = 1'b1;
        complete_sz(64'd777);

        // Asynchronous reset in the middle of RD_ISSUE.
        rd_cmd_ready = 1'b0;
        start_job(64'h9000, 64'd4096);
        repeat (2) tick();
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {69'd0, rd_cmd_valid, ap_idle, wr_start, sz_valid}, {69'd0, 4'b0100});
        chk("mid_rst_regs", {9'd0, wr_base | sz_addr | rd_cmd_addr}, 73'd0);
        tick();
        ap_rst_n = 1'b1;
        exp_q.delete();
        tick();
        run_row(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
